// File: rtl/hour_counter.sv
// rtl/hour_counter.sv - BCD hour counter 00..23 with carry, manual +/-1, optional 12-hour display (HOUR_COUNTER_12H_EN)
module hour_counter (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       INC,
  input  logic       DEC,
`ifdef HOUR_COUNTER_12H_EN
  input  logic       MODE12,
  output logic       PM,
`endif
  output logic [1:0] QH,
  output logic [3:0] QL,
  output logic       CA
);

  // h is the binary hour; ht/ho are its BCD digits, updated in lockstep
  logic [4:0] h, h_nxt;
  logic [1:0] ht, ht_nxt;
  logic [3:0] ho, ho_nxt;

  // Next-state: EN or INC count up (never twice), DEC counts down only when neither is high
  always_comb begin
    h_nxt  = h;
    ht_nxt = ht;
    ho_nxt = ho;
    if (EN || INC) begin
      if (h == 5'd23) begin
        h_nxt  = 5'd0;
        ht_nxt = 2'd0;
        ho_nxt = 4'd0;
      end else begin
        h_nxt = h + 5'd1;
        if (ho == 4'd9) begin
          ho_nxt = 4'd0;
          ht_nxt = ht + 2'd1;
        end else begin
          ho_nxt = ho + 4'd1;
        end
      end
    end else if (DEC) begin
      if (h == 5'd0) begin
        h_nxt  = 5'd23;
        ht_nxt = 2'd2;
        ho_nxt = 4'd3;
      end else begin
        h_nxt = h - 5'd1;
        if (ho == 4'd0) begin
          ho_nxt = 4'd9;
          ht_nxt = ht - 2'd1;
        end else begin
          ho_nxt = ho - 4'd1;
        end
      end
    end
  end

  // Hour registers with synchronous reset taking priority over any request
  always_ff @(posedge CLK) begin
    if (RST) begin
      h  <= 5'd0;
      ht <= 2'd0;
      ho <= 4'd0;
    end else begin
      h  <= h_nxt;
      ht <= ht_nxt;
      ho <= ho_nxt;
    end
  end

  // Day carry only on the minute-carry rollover, never from manual adjust or during reset
  always_comb begin
    CA = EN && (h == 5'd23) && !RST;
  end

`ifdef HOUR_COUNTER_12H_EN
  logic [3:0] h12;

  // 12-hour display mapping derived from the 24-hour count; PM is simply h >= 12
  always_comb begin
    PM = (h >= 5'd12);
    if (h == 5'd0)
      h12 = 4'd12;
    else if (h > 5'd12)
      h12 = 4'(h - 5'd12);
    else
      h12 = h[3:0];
    if (MODE12) begin
      QH = (h12 >= 4'd10) ? 2'd1 : 2'd0;
      QL = (h12 >= 4'd10) ? (h12 - 4'd10) : h12;
    end else begin
      QH = ht;
      QL = ho;
    end
  end
`else
  // 24-hour display straight from the BCD registers
  always_comb begin
    QH = ht;
    QL = ho;
  end
`endif

endmodule

// File: tb/tb_hour_counter.sv
// tb/tb_hour_counter.sv - directed self-checking bench for hour_counter
module tb_hour_counter;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       EN  = 1'b0;
  logic       INC = 1'b0;
  logic       DEC = 1'b0;
  logic [1:0] QH;
  logic [3:0] QL;
  logic       CA;
`ifdef HOUR_COUNTER_12H_EN
  logic       MODE12 = 1'b0;
  logic       PM;
`endif

  int pass_cnt = 0;
  int total    = 0;

  hour_counter dut (
    .CLK(CLK),
    .RST(RST),
    .EN(EN),
    .INC(INC),
    .DEC(DEC),
`ifdef HOUR_COUNTER_12H_EN
    .MODE12(MODE12),
    .PM(PM),
`endif
    .QH(QH),
    .QL(QL),
    .CA(CA)
  );

  always #5 CLK = ~CLK;

  task automatic drive(input logic en, input logic inc, input logic dec, input logic rst);
    @(negedge CLK);
    EN = en; INC = inc; DEC = dec; RST = rst;
  endtask

  task automatic clk_edge();
    @(posedge CLK);
    #1;
    EN = 1'b0; INC = 1'b0; DEC = 1'b0; RST = 1'b0;
  endtask

  task automatic step(input logic en, input logic inc, input logic dec, input logic rst);
    drive(en, inc, dec, rst);
    clk_edge();
  endtask

  task automatic go_to(input int hour);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < hour; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    total++; if (CA !== 1'b0) $display("FAIL reset_ca got=%0b exp=0", CA); else pass_cnt++;
    clk_edge();
    total++; if (QH !== 2'd0) $display("FAIL reset_qh got=%0d exp=0", QH); else pass_cnt++;
    total++; if (QL !== 4'd0) $display("FAIL reset_ql got=%0d exp=0", QL); else pass_cnt++;
  endtask

  task automatic test_en_sweep();
    int nh;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      total++;
      if (CA !== (i == 23)) $display("FAIL sweep_ca h=%0d got=%0b exp=%0b", i, CA, (i == 23));
      else pass_cnt++;
      clk_edge();
      nh = (i + 1) % 24;
      total++;
      if (QH !== 2'(nh / 10)) $display("FAIL sweep_qh h=%0d got=%0d exp=%0d", nh, QH, nh / 10);
      else pass_cnt++;
      total++;
      if (QL !== 4'(nh % 10)) $display("FAIL sweep_ql h=%0d got=%0d exp=%0d", nh, QL, nh % 10);
      else pass_cnt++;
    end
  endtask

  task automatic test_inc_dec();
    go_to(9);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    total++; if ({QH, QL} !== {2'd1, 4'd0}) $display("FAIL inc_09 got=%0d%0d exp=10", QH, QL); else pass_cnt++;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    total++; if ({QH, QL} !== {2'd0, 4'd9}) $display("FAIL dec_10 got=%0d%0d exp=09", QH, QL); else pass_cnt++;
    go_to(20);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    total++; if ({QH, QL} !== {2'd1, 4'd9}) $display("FAIL dec_20 got=%0d%0d exp=19", QH, QL); else pass_cnt++;
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    clk_edge();
    total++; if ({QH, QL} !== {2'd2, 4'd3}) $display("FAIL dec_00 got=%0d%0d exp=23", QH, QL); else pass_cnt++;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    total++; if (CA !== 1'b0) $display("FAIL dec_23_ca got=%0b exp=0", CA); else pass_cnt++;
    clk_edge();
    total++; if ({QH, QL} !== {2'd2, 4'd2}) $display("FAIL dec_23 got=%0d%0d exp=22", QH, QL); else pass_cnt++;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    total++; if (CA !== 1'b0) $display("FAIL inc_23_ca got=%0b exp=0", CA); else pass_cnt++;
    clk_edge();
    total++; if ({QH, QL} !== {2'd0, 4'd0}) $display("FAIL inc_23 got=%0d%0d exp=00", QH, QL); else pass_cnt++;
  endtask

  task automatic test_all_three();
    go_to(5);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    total++; if ({QH, QL} !== {2'd0, 4'd6}) $display("FAIL all_three got=%0d%0d exp=06", QH, QL); else pass_cnt++;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    total++; if ({QH, QL} !== {2'd0, 4'd7}) $display("FAIL en_dec got=%0d%0d exp=07", QH, QL); else pass_cnt++;
  endtask

  task automatic test_hold();
    go_to(14);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      total++; if ({QH, QL} !== {2'd1, 4'd4}) $display("FAIL hold got=%0d%0d exp=14", QH, QL); else pass_cnt++;
    end
  endtask

  task automatic test_reset_priority();
    go_to(23);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    total++; if (CA !== 1'b0) $display("FAIL rst_23_ca got=%0b exp=0", CA); else pass_cnt++;
    clk_edge();
    go_to(17);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    total++; if (CA !== 1'b0) $display("FAIL rst_17_ca got=%0b exp=0", CA); else pass_cnt++;
    clk_edge();
    total++; if ({QH, QL} !== {2'd0, 4'd0}) $display("FAIL rst_17 got=%0d%0d exp=00", QH, QL); else pass_cnt++;
  endtask

`ifdef HOUR_COUNTER_12H_EN
  task automatic test_mode12();
    MODE12 = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if ({QH, QL, PM} !== {2'd1, 4'd2, 1'b0}) $display("FAIL m12_h0 got=%0d%0d pm=%0b exp=12 pm=0", QH, QL, PM); else pass_cnt++;
    go_to(12);
    total++; if ({QH, QL, PM} !== {2'd1, 4'd2, 1'b1}) $display("FAIL m12_h12 got=%0d%0d pm=%0b exp=12 pm=1", QH, QL, PM); else pass_cnt++;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if ({QH, QL, PM} !== {2'd0, 4'd1, 1'b1}) $display("FAIL m12_h13 got=%0d%0d pm=%0b exp=01 pm=1", QH, QL, PM); else pass_cnt++;
    MODE12 = 1'b0;
    #1;
    total++; if ({QH, QL, PM} !== {2'd1, 4'd3, 1'b1}) $display("FAIL m24_h13 got=%0d%0d pm=%0b exp=13 pm=1", QH, QL, PM); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_en_sweep();
    test_inc_dec();
    test_wrap();
    test_all_three();
    test_hold();
    test_reset_priority();
`ifdef HOUR_COUNTER_12H_EN
    test_mode12();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/hour_counter.md
HOUR_COUNTER -- requirements
Module: hour_counter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLK input 1, rising-edge clock; RST input 1, synchronous active-high reset.
REQ-002 EN SHALL be an input, width 1: count-up enable, driven by the minute counter carry, one CLK cycle wide per hour.
REQ-003 INC SHALL be an input, width 1: manual +1 hour, pre-synchronised and edge-detected upstream, one cycle wide.
REQ-004 DEC SHALL be an input, width 1: manual -1 hour, one cycle wide.
REQ-005 QH SHALL be an output, width 2: tens digit of the displayed hour (BCD).
REQ-006 QL SHALL be an output, width 4: ones digit of the displayed hour (BCD).
REQ-007 CA SHALL be an output, width 1: day carry, combinational.
REQ-008 MODE12 (input, width 1) and PM (output, width 1) SHALL exist only when HOUR_COUNTER_12H_EN is defined.

Function
REQ-009 The block SHALL hold a registered hour count H in the range 0..23, with registered BCD digits HT (0..2) and HO (0..9) kept equal to H at every cycle.
REQ-010 When EN=1 or INC=1 at a CLK edge, H SHALL advance by exactly 1, even if both are high.
REQ-011 When EN=0, INC=0 and DEC=1, H SHALL decrement by 1.
REQ-012 DEC SHALL be ignored in any cycle where EN or INC is high.
REQ-013 On increment, HO=9 SHALL wrap to 0 and increment HT; 23 SHALL wrap to 00 (HT=0, HO=0). No value above 23 is ever reachable.
REQ-014 On decrement, HO=0 with HT>0 SHALL give HO=9 and decrement HT; 00 SHALL wrap to 23.
REQ-015 CA SHALL be 1 exactly when H=23 and EN=1; INC or DEC at 23 SHALL NOT raise CA.
REQ-016 When none of EN, INC or DEC is high, H SHALL hold.
REQ-017 The update latency SHALL be one cycle: a new value is visible on QH/QL after the CLK edge that samples the request.
REQ-018 Without the macro, QH=HT and QL=HO.

Reset
REQ-019 When RST=1 at a CLK edge, the block SHALL set H=0, HT=0 and HO=0, so QH=0 and QL=0.
REQ-020 RST SHALL take priority over EN, INC and DEC in the same cycle.
REQ-021 A reset mid-count SHALL discard the current hour with no carry pulse.
REQ-022 While RST=1, CA SHALL be 0.
REQ-023 Without the macro the block SHALL contain no state beyond H, HT and HO; with the macro, PM SHALL equal 0 after reset.

Configuration
REQ-024 HOUR_COUNTER_12H_EN defined: the 12-hour display path SHALL be compiled in. The internal count stays 0..23, and all counting and CA behaviour is unchanged.
REQ-025 With the macro and MODE12=1: the display SHALL map H=0 to 12 with PM=0, H=1..11 to 1..11 with PM=0, H=12 to 12 with PM=1, and H=13..23 to 1..11 with PM=1. QH/QL SHALL be combinational from the registers.
REQ-026 With the macro and MODE12=0: QH/QL SHALL equal HT/HO, and PM SHALL equal (H>=12).
REQ-027 HOUR_COUNTER_12H_EN undefined: the MODE12 and PM ports SHALL be absent, and the block SHALL be 24-hour only.

Verification
REQ-028 Reset then 24 EN pulses: the display SHALL step 00,01,...,23,00, with CA=1 only in the cycle where EN is high at 23.
REQ-029 From 09, one INC: QH=1, QL=0. From 10, one DEC: QH=0, QL=9.
REQ-030 From 23, one INC: the display SHALL show 00 and CA SHALL stay 0. From 00, one DEC: the display SHALL show 23.
REQ-031 At 05, EN=1, INC=1 and DEC=1 in the same cycle: the result SHALL be 06.
REQ-032 At 17, RST=1 together with EN=1: the result SHALL be 00 and CA SHALL be 0 in that cycle.
REQ-033 With the macro and MODE12=1: H=0 SHALL show 12 with PM=0; H=13 SHALL show 01 with PM=1; H=12 SHALL show 12 with PM=1.
